sram_sp_masked_init_ext: RTL and testbench



---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_init_ctrl.sv | 51 +++++
 rtl/sram_sp_masked_init_ext.sv | 95 +++++++++
 tb/tb_sram_sp_masked_init_ext.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and geometry helpers for the masked, self-initialising SRAM model.
package sram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } sram_state_e;

   // Address width for a given depth, kept at least one bit wide.
   function automatic int sram_clog2(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) bits++;
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Post-reset zeroing sweep: walks every entry once, then raises ready.
module sram_init_ctrl
   import sram_pkg::*;
#(
   parameter int DEPTH         = 1024,
   parameter int INIT_ON_RESET = 1,
   parameter int AW            = sram_clog2(DEPTH)
) (
   input  logic          RW0_clk,
   input  logic          reset,
   output logic          ready,
   output logic          init_we,
   output logic [AW-1:0] init_addr
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   sram_state_e   state_q, state_d;
   logic [AW-1:0] count_q, count_d;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge RW0_clk) begin
      if (reset) begin
         state_q <= (INIT_ON_RESET != 0) ? INIT : RUN;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         INIT: begin
            count_d = count_q + AW'(1);
            if (count_q == LAST_ADDR) state_d = RUN;
         end
         default: ;
      endcase
   end

   always_comb begin
      ready     = (state_q == RUN);
      init_we   = (state_q == INIT) && !reset;
      init_addr = count_q;
   end

endmodule

// File: rtl/sram_sp_masked_init_ext.sv
// Single-port SRAM with per-segment write mask, zeroing sweep after reset and optional held read data.
module sram_sp_masked_init_ext
   import sram_pkg::*;
#(
   parameter int DEPTH         = 1024,
   parameter int WIDTH         = 512,
   parameter int MASK_SEG      = 8,
   parameter int HOLD_RDATA    = 1,
   parameter int INIT_ON_RESET = 1,
   parameter int AW            = sram_clog2(DEPTH)
) (
   input  logic                RW0_clk,
   input  logic                reset,
   input  logic [AW-1:0]       RW0_addr,
   input  logic                RW0_en,
   input  logic                RW0_wmode,
   input  logic [MASK_SEG-1:0] RW0_wmask,
   input  logic [WIDTH-1:0]    RW0_wdata,
   output logic [WIDTH-1:0]    RW0_rdata,
   output logic                RW0_ready
);

   localparam int SW = WIDTH / MASK_SEG;

   logic [WIDTH-1:0] ram [DEPTH];

   logic                init_we;
   logic [AW-1:0]       init_addr;
   logic                accept, wr_acc, rd_acc;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [WIDTH-1:0]    wr_data;
   logic [MASK_SEG-1:0] wr_mask;

   sram_init_ctrl #(
      .DEPTH         (DEPTH),
      .INIT_ON_RESET (INIT_ON_RESET),
      .AW            (AW)
   ) u_init_ctrl (
      .RW0_clk   (RW0_clk),
      .reset     (reset),
      .ready     (RW0_ready),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   assign accept = RW0_en && RW0_ready && !reset;
   assign wr_acc = accept && RW0_wmode;
   assign rd_acc = accept && !RW0_wmode;

   // The sweep owns the write port while it runs; user requests are dropped then.
   always_comb begin
      wr_en   = wr_acc;
      wr_addr = RW0_addr;
      wr_data = RW0_wdata;
      wr_mask = RW0_wmask;
      if (init_we) begin
         wr_en   = 1'b1;
         wr_addr = init_addr;
         wr_data = '0;
         wr_mask = '1;
      end
   end

   // NOTE: the array has no reset; deterministic contents come from the sweep, not from reset.
   always_ff @(posedge RW0_clk) begin
      if (wr_en) begin
         for (int i = 0; i < MASK_SEG; i++) begin
            if (wr_mask[i]) ram[wr_addr][i*SW +: SW] <= wr_data[i*SW +: SW];
         end
      end
   end

   if (HOLD_RDATA != 0) begin : g_hold
      logic [WIDTH-1:0] rdata_q;

      always_ff @(posedge RW0_clk) begin
         if (reset)       rdata_q <= '0;
         else if (rd_acc) rdata_q <= ram[RW0_addr];
      end

      assign RW0_rdata = rdata_q;
   end else begin : g_live
      logic [AW-1:0] rd_addr_q;

      // Output follows the latched entry, so later writes to it show through.
      always_ff @(posedge RW0_clk) begin
         if (reset)       rd_addr_q <= '0;
         else if (rd_acc) rd_addr_q <= RW0_addr;
      end

      assign RW0_rdata = ram[rd_addr_q];
   end

endmodule

// File: tb/tb_sram_sp_masked_init_ext.sv
// Directed checks of the masked SRAM: held, live and no-sweep variants share one stimulus bus.
module tb_sram_sp_masked_init_ext;

   localparam int DEPTH = 16;
   localparam int WIDTH = 32;
   localparam int SEGS  = 4;
   localparam int AW    = 4;

   logic             clk;
   logic             reset;
   logic [AW-1:0]    addr;
   logic             en;
   logic             wmode;
   logic [SEGS-1:0]  wmask;
   logic [WIDTH-1:0] wdata;

   logic [WIDTH-1:0] rdata_a, rdata_b, rdata_c;
   logic             ready_a, ready_b, ready_c;

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // a: held rdata with sweep, b: live rdata with sweep, c: held rdata without sweep
   sram_sp_masked_init_ext #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEG(SEGS),
      .HOLD_RDATA(1), .INIT_ON_RESET(1)) dut_a (
      .RW0_clk(clk), .reset(reset), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
      .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata_a), .RW0_ready(ready_a));

   sram_sp_masked_init_ext #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEG(SEGS),
      .HOLD_RDATA(0), .INIT_ON_RESET(1)) dut_b (
      .RW0_clk(clk), .reset(reset), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
      .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata_b), .RW0_ready(ready_b));

   sram_sp_masked_init_ext #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEG(SEGS),
      .HOLD_RDATA(1), .INIT_ON_RESET(0)) dut_c (
      .RW0_clk(clk), .reset(reset), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
      .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata_c), .RW0_ready(ready_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                           input logic [SEGS-1:0] m);
      en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
      tick();
      en = 1'b0; wmode = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      en = 1'b1; wmode = 1'b0; addr = a;
      tick();
      en = 1'b0;
   endtask

   task automatic check_sweep(input string tag);
      for (int k = 0; k < DEPTH; k++) begin
         tick();
         check($sformatf("%s_ready_edge%0d", tag, k), {31'b0, ready_a}, (k == DEPTH - 1) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;
      tick();
      tick();
      check("rst_ready_a", {31'b0, ready_a}, 32'd0);
      check("rst_ready_b", {31'b0, ready_b}, 32'd0);
      check("rst_ready_c", {31'b0, ready_c}, 32'd1);
      check("rst_rdata_a", rdata_a, 32'h0);

      // Sweep with a read of addr 3 pending every cycle: dropped until ready.
      reset = 1'b0; en = 1'b1; wmode = 1'b0; addr = 4'd3;
      for (int k = 0; k < DEPTH; k++) begin
         tick();
         check($sformatf("sweep_ready_edge%0d", k), {31'b0, ready_a}, (k == DEPTH - 1) ? 32'd1 : 32'd0);
         check($sformatf("sweep_rdata_edge%0d", k), rdata_a, 32'h0);
      end
      tick();
      en = 1'b0;
      check("first_read_a", rdata_a, 32'h0);
      check("first_read_b", rdata_b, 32'h0);

      // Partial overwrite through mask 0x5 (segments 0 and 2).
      do_write(4'd5, 32'hAABBCCDD, 4'hF);
      do_write(4'd5, 32'h11223344, 4'h5);
      do_read(4'd5);
      check("mask_merge_a", rdata_a, 32'hAA22CC44);
      check("mask_merge_b", rdata_b, 32'hAA22CC44);

      // Held versus live read data after a write to the latched address.
      do_write(4'd2, 32'h12345678, 4'hF);
      do_read(4'd2);
      check("hold_before_a", rdata_a, 32'h12345678);
      check("live_before_b", rdata_b, 32'h12345678);
      do_write(4'd2, 32'hFFFFFFFF, 4'hF);
      check("hold_after_a", rdata_a, 32'h12345678);
      check("live_after_b", rdata_b, 32'hFFFFFFFF);
      tick();
      check("hold_idle_a", rdata_a, 32'h12345678);

      // Back-to-back write then read of the same entry.
      do_write(4'd9, 32'hCAFEF00D, 4'hF);
      do_read(4'd9);
      check("raw_a", rdata_a, 32'hCAFEF00D);
      check("raw_b", rdata_b, 32'hCAFEF00D);

      // All-zero mask leaves the entry untouched (also exercises the no-sweep instance).
      do_write(4'd7, 32'h0BADF00D, 4'hF);
      do_write(4'd7, 32'h00000000, 4'h0);
      do_read(4'd7);
      check("nomask_a", rdata_a, 32'h0BADF00D);
      check("nomask_b", rdata_b, 32'h0BADF00D);
      check("nomask_c", rdata_c, 32'h0BADF00D);

      // Fill, reset in RUN, reset again five cycles into the sweep.
      for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 32'hDEADBEEF, 4'hF);
      reset = 1'b1;
      tick();
      check("rerun_rdata_a", rdata_a, 32'h0);
      check("rerun_ready_a", {31'b0, ready_a}, 32'd0);
      check("rerun_ready_c", {31'b0, ready_c}, 32'd1);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("partial_ready_edge%0d", k), {31'b0, ready_a}, 32'd0);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_sweep("resweep");
      check("resweep_ready_b", {31'b0, ready_b}, 32'd1);
      check("resweep_live_b", rdata_b, 32'h0);

      for (int i = 0; i < DEPTH; i++) begin
         do_read(AW'(i));
         check($sformatf("cleared_a_%0d", i), rdata_a, 32'h0);
         check($sformatf("cleared_b_%0d", i), rdata_b, 32'h0);
         check($sformatf("kept_c_%0d", i), rdata_c, 32'hDEADBEEF);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
